// File: rtl/dmem_if.sv
// Data-memory request/response bus between the memory-access stage and its responder.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian store, 8-byte accesses,
// fixed access latency, one outstanding request at a time.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | request captured, counting down the access latency
//   RESP  | result committed, response held until consumed
module dmem_responder #(
   parameter int MEM_BYTES = 1024,
   parameter int LATENCY   = 2
) (
   input  logic   clk_i,
   input  logic   rst_n_i,
   dmem_if.slave  bus
);

   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [63:0] rdata_q;
   logic        error_q;

   logic [7:0]  mem [MEM_BYTES];

   logic        accept;
   logic        commit;
   logic        c_write;
   logic [63:0] c_addr;
   logic [63:0] c_wdata;
   logic        c_err;
   logic [AW-1:0] base;
   logic [63:0] rd_word;

   assign accept = (state_q == IDLE) && bus.req_valid;
   assign commit = (state_d == RESP) && (state_q != RESP);

   // With LATENCY==1 the commit lands on the accept edge itself, so the live
   // request is used there instead of the (not yet loaded) capture registers.
   assign c_write = (state_q == IDLE) ? bus.req_write : write_q;
   assign c_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
   assign c_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
   assign c_err   = c_addr > 64'(MEM_BYTES - 8);
   assign base    = c_addr[AW-1:0];

   // Gather the little-endian load word at the commit address.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < 8; k++) begin
         rd_word[8*k +: 8] = mem[base + AW'(k)];
      end
   end

   // Next-state and latency-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            cnt_d = '0;
            if (bus.resp_ready) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, capture and response registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (commit) begin
            error_q <= c_err;
            rdata_q <= (c_err || c_write) ? 64'd0 : rd_word;
         end else if (state_q == RESP && bus.resp_ready) begin
            error_q <= 1'b0;
            rdata_q <= '0;
         end
      end
   end

   // Store path; contents survive reset on purpose.
   always_ff @(posedge clk_i) begin
      if (commit && c_write && !c_err) begin
         for (int k = 0; k < 8; k++) begin
            mem[base + AW'(k)] <= c_wdata[8*k +: 8];
         end
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 4, 1) driven one at a
// time through a selector, checked against a byte-array reference model.
module tb_dmem_responder;

   localparam int L0 = 2;
   localparam int L1 = 4;
   localparam int L2 = 1;

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   always #5 clk_i = ~clk_i;

   dmem_if if0();
   dmem_if if1();
   dmem_if if2();

   dmem_responder #(.MEM_BYTES(1024), .LATENCY(L0)) u0 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(if0.slave));
   dmem_responder #(.MEM_BYTES(1024), .LATENCY(L1)) u1 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(if1.slave));
   dmem_responder #(.MEM_BYTES(1024), .LATENCY(L2)) u2 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(if2.slave));

   int          sel = 0;
   logic        drv_valid = 1'b0;
   logic        drv_write = 1'b0;
   logic [63:0] drv_addr = '0;
   logic [63:0] drv_wdata = '0;
   logic        drv_resp_ready = 1'b0;

   assign if0.req_valid = drv_valid && (sel == 0);
   assign if1.req_valid = drv_valid && (sel == 1);
   assign if2.req_valid = drv_valid && (sel == 2);
   assign if0.resp_ready = drv_resp_ready && (sel == 0);
   assign if1.resp_ready = drv_resp_ready && (sel == 1);
   assign if2.resp_ready = drv_resp_ready && (sel == 2);
   assign if0.req_write = drv_write;
   assign if1.req_write = drv_write;
   assign if2.req_write = drv_write;
   assign if0.req_addr = drv_addr;
   assign if1.req_addr = drv_addr;
   assign if2.req_addr = drv_addr;
   assign if0.req_wdata = drv_wdata;
   assign if1.req_wdata = drv_wdata;
   assign if2.req_wdata = drv_wdata;

   int passed = 0;
   int total = 0;

   logic [7:0] mm [3][1024];

   function automatic logic o_ready();
      return (sel == 0) ? if0.req_ready : (sel == 1) ? if1.req_ready : if2.req_ready;
   endfunction
   function automatic logic o_valid();
      return (sel == 0) ? if0.resp_valid : (sel == 1) ? if1.resp_valid : if2.resp_valid;
   endfunction
   function automatic logic [63:0] o_rdata();
      return (sel == 0) ? if0.resp_rdata : (sel == 1) ? if1.resp_rdata : if2.resp_rdata;
   endfunction
   function automatic logic o_error();
      return (sel == 0) ? if0.resp_error : (sel == 1) ? if1.resp_error : if2.resp_error;
   endfunction
   function automatic int lat_of(input int s);
      return (s == 0) ? L0 : (s == 1) ? L1 : L2;
   endfunction

   // Reference: whole-word access on a byte array, range rule on all 8 bytes.
   function automatic void model_access(input int s, input bit w, input logic [63:0] a,
                                        input logic [63:0] d, output logic [63:0] r, output bit e);
      r = '0;
      e = (a > 64'd1016);
      if (!e) begin
         for (int k = 0; k < 8; k++) begin
            if (w) mm[s][int'(a) + k] = d[8*k +: 8];
            else   r[8*k +: 8] = mm[s][int'(a) + k];
         end
      end
   endfunction

   task automatic issue(input int s, input bit w, input logic [63:0] a, input logic [63:0] d);
      int n = 0;
      sel = s;
      while (!o_ready() && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (n == 50) begin
         total++;
         $display("FAIL issue_timeout: req_ready stayed %0b, required 1", o_ready());
      end
      drv_valid = 1'b1;
      drv_write = w;
      drv_addr  = a;
      drv_wdata = d;
      @(negedge clk_i);
      drv_valid = 1'b0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 1;
      while (!o_valid() && lat < 40) begin
         @(negedge clk_i);
         lat++;
      end
   endtask

   task automatic do_req(input int s, input bit w, input logic [63:0] a, input logic [63:0] d);
      logic [63:0] er;
      bit ee;
      int lat;
      issue(s, w, a, d);
      model_access(s, w, a, d, er, ee);
      wait_resp(lat);
      total++;
      if (lat != lat_of(s)) $display("FAIL latency addr=%h: got %0d, required %0d", a, lat, lat_of(s));
      else passed++;
      total++;
      if (o_rdata() !== er) $display("FAIL rdata addr=%h w=%0b: got %h, required %h", a, w, o_rdata(), er);
      else passed++;
      total++;
      if (o_error() !== ee) $display("FAIL error addr=%h: got %0b, required %0b", a, o_error(), ee);
      else passed++;
      drv_resp_ready = 1'b1;
      @(negedge clk_i);
      drv_resp_ready = 1'b0;
      total++;
      if (o_valid() !== 1'b0 || o_ready() !== 1'b1 || o_rdata() !== 64'd0 || o_error() !== 1'b0)
         $display("FAIL post_handshake: valid=%0b ready=%0b rdata=%h err=%0b, required 0 1 0 0",
                  o_valid(), o_ready(), o_rdata(), o_error());
      else passed++;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      repeat (3) @(negedge clk_i);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         total++;
         if (o_ready() !== 1'b1 || o_valid() !== 1'b0 || o_rdata() !== 64'd0 || o_error() !== 1'b0)
            $display("FAIL reset_state dut%0d: ready=%0b valid=%0b rdata=%h err=%0b, required 1 0 0 0",
                     s, o_ready(), o_valid(), o_rdata(), o_error());
         else passed++;
      end
      rst_n_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_basic();
      do_req(0, 1'b1, 64'h10, 64'h1122334455667788);
      do_req(0, 1'b0, 64'h10, 64'h0);
      do_req(0, 1'b0, 64'h14, 64'h0);
      do_req(0, 1'b0, 64'h0C, 64'h0);
      total++;
      if (mm[0][16] !== 8'h88 || mm[0][23] !== 8'h11)
         $display("FAIL model_byte_order: got %h %h, required 88 11", mm[0][16], mm[0][23]);
      else passed++;
   endtask

   task automatic test_boundary();
      do_req(0, 1'b1, 64'd1016, 64'hA1B2C3D4E5F60718);
      do_req(0, 1'b0, 64'd1016, 64'h0);
      do_req(0, 1'b0, 64'd1017, 64'h0);
      do_req(0, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0);
      do_req(0, 1'b1, 64'd1017, 64'hDEADBEEFCAFEF00D);
      do_req(0, 1'b0, 64'd1016, 64'h0);
   endtask

   task automatic test_backpressure();
      logic [63:0] er, r0;
      bit ee, e0;
      int lat;
      issue(0, 1'b0, 64'h10, 64'h0);
      model_access(0, 1'b0, 64'h10, 64'h0, er, ee);
      wait_resp(lat);
      r0 = o_rdata();
      e0 = o_error();
      total++;
      if (r0 !== er) $display("FAIL bp_rdata: got %h, required %h", r0, er);
      else passed++;
      drv_valid = 1'b1;
      drv_write = 1'b1;
      drv_addr  = 64'h40;
      drv_wdata = 64'h0F0E0D0C0B0A0908;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         total++;
         if (o_valid() !== 1'b1 || o_rdata() !== er || o_error() !== ee || o_ready() !== 1'b0)
            $display("FAIL bp_hold cycle %0d: valid=%0b rdata=%h err=%0b ready=%0b, required 1 %h %0b 0",
                     i, o_valid(), o_rdata(), o_error(), o_ready(), er, ee);
         else passed++;
      end
      drv_resp_ready = 1'b1;
      @(negedge clk_i);
      drv_resp_ready = 1'b0;
      total++;
      if (o_valid() !== 1'b0 || o_ready() !== 1'b1)
         $display("FAIL bp_release: valid=%0b ready=%0b, required 0 1", o_valid(), o_ready());
      else passed++;
      @(negedge clk_i);
      drv_valid = 1'b0;
      model_access(0, 1'b1, 64'h40, 64'h0F0E0D0C0B0A0908, er, ee);
      wait_resp(lat);
      total++;
      if (lat != L0) $display("FAIL bp_second_latency: got %0d, required %0d", lat, L0);
      else passed++;
      drv_resp_ready = 1'b1;
      @(negedge clk_i);
      drv_resp_ready = 1'b0;
      do_req(0, 1'b0, 64'h40, 64'h0);
   endtask

   task automatic test_reset_midop();
      issue(1, 1'b1, 64'h20, 64'h5A5A5A5A5A5A5A5A);
      total++;
      if (o_ready() !== 1'b0 || o_valid() !== 1'b0)
         $display("FAIL midop_wait: ready=%0b valid=%0b, required 0 0", o_ready(), o_valid());
      else passed++;
      rst_n_i = 1'b0;
      #1;
      total++;
      if (o_ready() !== 1'b1 || o_valid() !== 1'b0 || o_rdata() !== 64'd0 || o_error() !== 1'b0)
         $display("FAIL midop_reset: ready=%0b valid=%0b rdata=%h err=%0b, required 1 0 0 0",
                  o_ready(), o_valid(), o_rdata(), o_error());
      else passed++;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      do_req(1, 1'b0, 64'h20, 64'h0);
   endtask

   task automatic test_back_to_back();
      logic [63:0] er;
      bit ee;
      int last_acc = -10;
      int n_acc = 0;
      do_req(2, 1'b1, 64'h80, 64'h0123456789ABCDEF);
      model_access(2, 1'b0, 64'h80, 64'h0, er, ee);
      drv_valid = 1'b1;
      drv_write = 1'b0;
      drv_addr  = 64'h80;
      drv_resp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (last_acc == i - 1) begin
            total++;
            if (o_valid() !== 1'b1 || o_rdata() !== er)
               $display("FAIL b2b_resp cycle %0d: valid=%0b rdata=%h, required 1 %h", i, o_valid(), o_rdata(), er);
            else passed++;
         end
         if (o_ready()) begin
            if (last_acc >= 0) begin
               total++;
               if (i - last_acc != 2) $display("FAIL b2b_spacing: got %0d, required 2", i - last_acc);
               else passed++;
            end
            last_acc = i;
            n_acc++;
         end
         if (i == 11) drv_valid = 1'b0;
         @(negedge clk_i);
      end
      @(negedge clk_i);
      drv_resp_ready = 1'b0;
      total++;
      if (n_acc != 6) $display("FAIL b2b_count: got %0d, required 6", n_acc);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int s, c;
         bit w;
         logic [63:0] a, d;
         s = $urandom_range(0, 2);
         w = 1'($urandom_range(0, 1));
         c = $urandom_range(0, 9);
         if (c < 5)       a = 64'($urandom_range(0, 64));
         else if (c < 8)  a = 64'($urandom_range(0, 1016));
         else if (c == 8) a = 64'($urandom_range(1017, 1023));
         else             a = {32'($urandom) | 32'h1, 32'($urandom)};
         d = {32'($urandom), 32'($urandom)};
         do_req(s, w, a, d);
      end
   endtask

   initial begin
      for (int s = 0; s < 3; s++)
         for (int b = 0; b < 1024; b++)
            mm[s][b] = 8'h00;
      @(negedge clk_i);
      test_reset();
      test_basic();
      test_boundary();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
